// File: rtl/score_bcd_encoder.sv
// Binary score to three BCD digit codes using a one-bit-per-clock double-dabble engine.
// New digits are committed only on startOfFrame so a displayed score never tears mid-frame.
module score_bcd_encoder #(
  parameter int WIDTH         = 8,
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             digitsValid,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_FRAME} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   bin;
  logic [11:0]        bcd;
  logic [CNT_W-1:0]   cnt;
  logic               pending;
  logic [WIDTH-1:0]   pend_val;

  logic               start_conv;
  logic [WIDTH-1:0]   start_val;
  logic               commit;
  logic [11:0]        bcd_adj;
  logic [11+WIDTH:0]  shifted;
  logic [3:0]         hun_code, ten_code;

  // Each nibble is corrected independently; a corrected nibble never exceeds 4'hC, so no carry escapes.
  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_n    = state;
    start_conv = 1'b0;
    start_val  = value;
    commit     = 1'b0;
    bcd_adj    = add3(bcd);
    shifted    = {bcd_adj, bin} << 1;
    unique case (state)
      IDLE: begin
        // A request captured on the last commit edge is started here if no fresh load arrives.
        if (load || pending) begin
          start_conv = 1'b1;
          start_val  = load ? value : pend_val;
          state_n    = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(WIDTH - 1)) state_n = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (startOfFrame) begin
          commit = 1'b1;
          if (pending) begin
            start_conv = 1'b1;
            start_val  = pend_val;
            state_n    = SHIFT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    hun_code = bcd[11:8];
    ten_code = bcd[7:4];
    if (BLANK_LEADING && bcd[11:8] == 4'd0) begin
      hun_code = 4'hF;
      if (bcd[7:4] == 4'd0) ten_code = 4'hF;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      pending  <= 1'b0;
      pend_val <= '0;
    end else begin
      if (start_conv) begin
        bin <= start_val;
        bcd <= '0;
        cnt <= '0;
      end else if (state == SHIFT) begin
        {bcd, bin} <= shifted;
        cnt        <= cnt + 1'b1;
      end

      // A conversion start consumes the pending request; a load outside IDLE (re)arms it.
      if (start_conv) pending <= 1'b0;
      if (load && state != IDLE) begin
        pending  <= 1'b1;
        pend_val <= value;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hundreds    <= 4'd0;
      tens        <= 4'd0;
      ones        <= 4'd0;
      digitsValid <= 1'b0;
    end else if (commit) begin
      hundreds    <= hun_code;
      tens        <= ten_code;
      ones        <= bcd[3:0];
      digitsValid <= 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule
